// File: rtl/serial_correlator.sv
// serial_correlator: bit-serial popcount correlator of two WIDTH-bit operands.
// Each RUN cycle consumes LANES bit pairs. The pair term is a&b (mode=0) or
// ~(a^b) (mode=1), and the count of true terms is accumulated.
// Ports:
//   clock, reset (async, active-high)
//   start, mode, a, b : request, with operands captured on acceptance
//   busy   : high while the bit pairs are being consumed
//   done   : one-cycle pulse when result is updated
//   result : last completed count, held between completions
module serial_correlator #(
   parameter  int WIDTH = 6,
   parameter  int LANES = 1,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] result
);

   localparam int BEATS = WIDTH / LANES;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [WIDTH-1:0] sa, sb;
   logic             mode_q;
   logic [CNT_W-1:0] acc;
   logic [BW-1:0]    cnt;
   logic [CNT_W-1:0] term;
   logic [CNT_W-1:0] sum;
   logic             last;
   logic             load;

   // Popcount of the LANES low-order pair terms.
   always_comb begin
      term = '0;
      for (int i = 0; i < LANES; i++) begin
         if (mode_q ? (sa[i] ~^ sb[i]) : (sa[i] & sb[i]))
            term = term + CNT_W'(1);
      end
   end

   assign sum  = acc + term;
   assign last = (cnt == LAST);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               load    = 1'b1;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last) state_d = DONE;
         end
         DONE: begin
            done = 1'b1;
            // A start here restarts immediately with no IDLE cycle.
            if (start) begin
               state_d = RUN;
               load    = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sa     <= '0;
         sb     <= '0;
         mode_q <= 1'b0;
         acc    <= '0;
         cnt    <= '0;
         result <= '0;
      end else if (load) begin
         sa     <= a;
         sb     <= b;
         mode_q <= mode;
         acc    <= '0;
         cnt    <= '0;
      end else if (state_q == RUN) begin
         acc <= sum;
         sa  <= sa >> LANES;
         sb  <= sb >> LANES;
         cnt <= cnt + BW'(1);
         if (last) result <= sum;
      end
   end

endmodule
